// File: rtl/alu_pipe_system.sv
// alu_pipe_system: registered ALU with single-cycle ops and an optional
// iterative shift-add multiplier (opcode 9), enabled by the macro
// ALU_PIPE_MUL_EN. Without the macro opcode 9 is reported as illegal and
// the block is always ready.
module alu_pipe_system #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] Imm,
    input  logic             ALUsrc,
    input  logic [3:0]       ALUop,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] ALUout,
    output logic             AltB,
    output logic [3:0]       flags,
    output logic             op_err
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    typedef enum logic {IDLE = 1'b0, MUL_BUSY = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] aluout_q, aluout_d;
    logic             altb_q, altb_d;
    logic [3:0]       flags_q, flags_d;
    logic             operr_q, operr_d;
    logic             outvalid_q, outvalid_d;

`ifdef ALU_PIPE_MUL_EN
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] accNext;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               altbPend_q, altbPend_d;
    logic               isMul;
`endif

    logic [WIDTH-1:0] Bm;
    logic [SHW-1:0]   shamt;
    logic             accept;
    logic [WIDTH:0]   addExt, subExt, sllExt, srlExt, sraExt;
    logic             altbC;
    logic [WIDTH-1:0] opRes;
    logic             opC, opV, opErr;

    assign Bm     = ALUsrc ? B : Imm;
    assign shamt  = Bm[SHW-1:0];
    assign accept = in_valid && in_ready;
    assign altbC  = $signed(A) < $signed(Bm);

    // Extended arithmetic/shift results; the extra bit carries C so a shift
    // by zero naturally yields C=0.
    assign addExt = {1'b0, A} + {1'b0, Bm};
    assign subExt = {1'b0, A} + {1'b0, ~Bm} + {{WIDTH{1'b0}}, 1'b1};
    assign sllExt = {1'b0, A} << shamt;
    assign srlExt = {A, 1'b0} >> shamt;
    assign sraExt = $signed({A, 1'b0}) >>> shamt;

`ifdef ALU_PIPE_MUL_EN
    assign in_ready = (state_q == IDLE);
    assign accNext  = acc_q + (mplier_q[0] ? mcand_q : {2*WIDTH{1'b0}});
`else
    assign in_ready = 1'b1;
`endif

    // Decode the opcode into a single-cycle result, carry, overflow and error.
    always_comb begin
        opRes = '0;
        opC   = 1'b0;
        opV   = 1'b0;
        opErr = 1'b0;
`ifdef ALU_PIPE_MUL_EN
        isMul = 1'b0;
`endif
        case (ALUop)
            OP_ADD: begin
                opRes = addExt[WIDTH-1:0];
                opC   = addExt[WIDTH];
                opV   = (A[WIDTH-1] == Bm[WIDTH-1]) && (addExt[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                opRes = subExt[WIDTH-1:0];
                opC   = subExt[WIDTH];
                opV   = (A[WIDTH-1] != Bm[WIDTH-1]) && (subExt[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: opRes = A & Bm;
            OP_OR:  opRes = A | Bm;
            OP_XOR: opRes = A ^ Bm;
            OP_SLT: opRes = {{(WIDTH-1){1'b0}}, altbC};
            OP_SLL: begin
                opRes = sllExt[WIDTH-1:0];
                opC   = sllExt[WIDTH];
            end
            OP_SRL: begin
                opRes = srlExt[WIDTH:1];
                opC   = srlExt[0];
            end
            OP_SRA: begin
                opRes = sraExt[WIDTH:1];
                opC   = sraExt[0];
            end
            OP_MUL: begin
`ifdef ALU_PIPE_MUL_EN
                isMul = 1'b1;
`else
                opErr = 1'b1;
`endif
            end
            default: opErr = 1'b1;
        endcase
    end

    // Next-state and output-register logic; outputs hold unless a result lands.
    always_comb begin
        state_d    = state_q;
        aluout_d   = aluout_q;
        altb_d     = altb_q;
        flags_d    = flags_q;
        operr_d    = operr_q;
        outvalid_d = 1'b0;
`ifdef ALU_PIPE_MUL_EN
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        mplier_d   = mplier_q;
        altbPend_d = altbPend_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef ALU_PIPE_MUL_EN
                    if (isMul) begin
                        state_d    = MUL_BUSY;
                        cnt_d      = '0;
                        mcand_d    = {{WIDTH{1'b0}}, A};
                        mplier_d   = Bm;
                        acc_d      = '0;
                        altbPend_d = altbC;
                    end else begin
`endif
                        aluout_d   = opErr ? '0 : opRes;
                        flags_d    = opErr ? 4'b0000 : {opRes[WIDTH-1], ~|opRes, opC, opV};
                        operr_d    = opErr;
                        altb_d     = altbC;
                        outvalid_d = 1'b1;
`ifdef ALU_PIPE_MUL_EN
                    end
`endif
                end
            end
            MUL_BUSY: begin
`ifdef ALU_PIPE_MUL_EN
                acc_d    = accNext;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    aluout_d   = accNext[WIDTH-1:0];
                    flags_d    = {accNext[WIDTH-1], ~|accNext[WIDTH-1:0],
                                  |accNext[2*WIDTH-1:WIDTH], |accNext[2*WIDTH-1:WIDTH]};
                    operr_d    = 1'b0;
                    altb_d     = altbPend_q;
                    outvalid_d = 1'b1;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            aluout_q   <= '0;
            altb_q     <= 1'b0;
            flags_q    <= 4'b0000;
            operr_q    <= 1'b0;
            outvalid_q <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
            cnt_q      <= '0;
            mcand_q    <= '0;
            acc_q      <= '0;
            mplier_q   <= '0;
            altbPend_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            aluout_q   <= aluout_d;
            altb_q     <= altb_d;
            flags_q    <= flags_d;
            operr_q    <= operr_d;
            outvalid_q <= outvalid_d;
`ifdef ALU_PIPE_MUL_EN
            cnt_q      <= cnt_d;
            mcand_q    <= mcand_d;
            acc_q      <= acc_d;
            mplier_q   <= mplier_d;
            altbPend_q <= altbPend_d;
`endif
        end
    end

    assign out_valid = outvalid_q;
    assign ALUout    = aluout_q;
    assign AltB      = altb_q;
    assign flags     = flags_q;
    assign op_err    = operr_q;

endmodule

// File: tb/tb_alu_pipe_system.sv
// Self-checking bench for alu_pipe_system (WIDTH=16): directed literal cases
// plus randomized requests compared every cycle against a behavioural model.
module tb_alu_pipe_system;

`ifdef ALU_PIPE_MUL_EN
    localparam bit mulEn = 1'b1;
`else
    localparam bit mulEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] A = '0, B = '0, Imm = '0;
    logic        ALUsrc = 1'b0;
    logic [3:0]  ALUop = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, out_valid, AltB, op_err;
    logic [15:0] ALUout;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    // Model state: expected held outputs and pending multiply.
    int          busyLeft = 0;
    logic        expValid = 1'b0;
    logic [15:0] expOut = '0;
    logic        expAltb = 1'b0;
    logic [3:0]  expFlags = '0;
    logic        expErr = 1'b0;
    logic [21:0] pending = '0;
    logic [21:0] mdlRes;

    alu_pipe_system #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Imm(Imm), .ALUsrc(ALUsrc),
        .ALUop(ALUop), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .ALUout(ALUout), .AltB(AltB), .flags(flags),
        .op_err(op_err)
    );

    always #5 clk = ~clk;

    // Reference ALU from the arithmetic rules: returns {err, altb, flags, result}.
    function automatic logic [21:0] refAlu(input logic [15:0] a, input logic [15:0] bm,
                                           input logic [3:0] op);
        int sa, sb, tmp, sh;
        longint prod;
        logic [15:0] r;
        logic c, v, err;
        logic [3:0] f;
        sa = int'($signed(a));
        sb = int'($signed(bm));
        sh = int'(bm[3:0]);
        r = '0; c = 1'b0; v = 1'b0; err = 1'b0;
        case (op)
            4'd0: begin
                tmp = int'(a) + int'(bm); r = tmp[15:0]; c = (tmp > 65535);
                tmp = sa + sb; v = (tmp > 32767) || (tmp < -32768);
            end
            4'd1: begin
                tmp = int'(a) - int'(bm); r = tmp[15:0]; c = (a >= bm);
                tmp = sa - sb; v = (tmp > 32767) || (tmp < -32768);
            end
            4'd2: r = a & bm;
            4'd3: r = a | bm;
            4'd4: r = a ^ bm;
            4'd5: r = (sa < sb) ? 16'd1 : 16'd0;
            4'd6: begin r = a << sh; c = (sh != 0) ? a[16 - sh] : 1'b0; end
            4'd7: begin r = a >> sh; c = (sh != 0) ? a[sh - 1] : 1'b0; end
            4'd8: begin tmp = sa >>> sh; r = tmp[15:0]; c = (sh != 0) ? a[sh - 1] : 1'b0; end
            4'd9: begin
                if (mulEn) begin
                    prod = longint'(a) * longint'(bm);
                    r = prod[15:0]; c = (prod > 65535); v = c;
                end else err = 1'b1;
            end
            default: err = 1'b1;
        endcase
        if (err) r = '0;
        f = err ? 4'b0000 : {r[15], (r == 16'd0), c, v};
        return {err, (sa < sb), f, r};
    endfunction

    // Behavioural model: tracks busy time and the outputs each edge must show.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busyLeft <= 0; expValid <= 1'b0; expOut <= '0;
            expAltb <= 1'b0; expFlags <= '0; expErr <= 1'b0;
        end else begin
            expValid <= 1'b0;
            if (busyLeft > 0) begin
                busyLeft <= busyLeft - 1;
                if (busyLeft == 1) begin
                    {expErr, expAltb, expFlags, expOut} <= pending;
                    expValid <= 1'b1;
                end
            end else if (in_valid) begin
                mdlRes = refAlu(A, ALUsrc ? B : Imm, ALUop);
                if (ALUop == 4'd9 && mulEn) begin
                    pending <= mdlRes;
                    busyLeft <= 16;
                end else begin
                    {expErr, expAltb, expFlags, expOut} <= mdlRes;
                    expValid <= 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("cyc_in_ready", in_ready, mulEn ? (busyLeft == 0) : 1'b1);
            checkOutput("cyc_out_valid", out_valid, expValid);
            checkOutput("cyc_ALUout", ALUout, expOut);
            checkOutput("cyc_AltB", AltB, expAltb);
            checkOutput("cyc_flags", flags, expFlags);
            checkOutput("cyc_op_err", op_err, expErr);
        end
    end

    // Present one request for one cycle; returns at the falling edge after it.
    task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic [15:0] imm, input logic src);
        @(negedge clk);
        ALUop = op; A = a; B = b; Imm = imm; ALUsrc = src; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cycles;
        repeat (3) @(negedge clk);
        checkOutput("rst_ALUout", ALUout, 16'h0000);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_in_ready", in_ready, 1'b1);
        checkOutput("rst_flags", flags, 4'b0000);
        #2 rst_n = 1'b1;
        checkEn = 1'b1;

        applyStimulus(4'd0, 16'h7FFF, 16'h0001, 16'h0000, 1'b1);
        checkOutput("add_out", ALUout, 16'h8000);
        checkOutput("add_flags", flags, 4'b1001);
        checkOutput("add_altb", AltB, 1'b0);
        checkOutput("add_valid", out_valid, 1'b1);
        @(negedge clk);
        checkOutput("add_valid_drop", out_valid, 1'b0);
        checkOutput("add_hold", ALUout, 16'h8000);

        applyStimulus(4'd1, 16'd5, 16'hAAAA, 16'd5, 1'b0);
        checkOutput("sub_out", ALUout, 16'h0000);
        checkOutput("sub_flags", flags, 4'b0110);
        checkOutput("sub_altb", AltB, 1'b0);
        applyStimulus(4'd5, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        checkOutput("slt_out", ALUout, 16'h0001);
        checkOutput("slt_altb", AltB, 1'b1);

        applyStimulus(4'd8, 16'h8001, 16'h0011, 16'h0000, 1'b1);
        checkOutput("sra_out", ALUout, 16'hC000);
        checkOutput("sra_flags", flags, 4'b1010);

        applyStimulus(4'd6, 16'h8001, 16'h0000, 16'h0000, 1'b0);
        checkOutput("sll0_out", ALUout, 16'h8001);
        checkOutput("sll0_flags", flags, 4'b1000);
        applyStimulus(4'd6, 16'h8001, 16'h0001, 16'h0000, 1'b1);
        checkOutput("sll1_out", ALUout, 16'h0002);
        checkOutput("sll1_flags", flags, 4'b0010);

        applyStimulus(4'hC, 16'h1234, 16'h5678, 16'h0000, 1'b1);
        checkOutput("ill_err", op_err, 1'b1);
        checkOutput("ill_out", ALUout, 16'h0000);
        checkOutput("ill_flags", flags, 4'b0000);

        applyStimulus(4'd9, 16'd300, 16'd300, 16'h0000, 1'b1);
        if (mulEn) begin
            checkOutput("mul_busy", in_ready, 1'b0);
            cycles = 0;
            while (!out_valid && cycles < 40) begin
                if (cycles == 3) begin
                    ALUop = 4'd0; A = 16'd1; B = 16'd1; in_valid = 1'b1;
                end else in_valid = 1'b0;
                @(negedge clk);
                cycles++;
            end
            in_valid = 1'b0;
            checkOutput("mul_latency", cycles, 16);
            checkOutput("mul_out", ALUout, 16'h5F90);
            checkOutput("mul_flags", flags, 4'b0011);
            checkOutput("mul_err", op_err, 1'b0);
            repeat (3) @(negedge clk);
            checkOutput("mul_drop", ALUout, 16'h5F90);
        end else begin
            checkOutput("mul_ill_err", op_err, 1'b1);
            checkOutput("mul_ill_valid", out_valid, 1'b1);
        end

        applyStimulus(4'd9, 16'd300, 16'd300, 16'h0000, 1'b1);
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_valid", out_valid, 1'b0);
        checkOutput("abort_out", ALUout, 16'h0000);
        checkOutput("abort_ready", in_ready, 1'b1);
        checkOutput("abort_flags", flags, 4'b0000);
        #2 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("abort_nopulse", ALUout, 16'h0000);
        applyStimulus(4'd0, 16'd1, 16'd2, 16'h0000, 1'b1);
        checkOutput("post_add", ALUout, 16'h0003);
        checkOutput("post_valid", out_valid, 1'b1);

        for (int i = 0; i < 300; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
                          16'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (30) @(negedge clk);
        checkEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_pipe_system.md
ALU_PIPE_SYSTEM -- requirements
Module: alu_pipe_system

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning datapath width in bits (legal: 8, 16, 32).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), meaning shift-amount width.
REQ-003 SHALL have one clock and an asynchronous active-low reset.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 A  input  WIDTH  operand A.
REQ-007 B  input  WIDTH  register operand B.
REQ-008 Imm  input  WIDTH  immediate operand.
REQ-009 ALUsrc  input  1  selects B when 1 and Imm when 0, giving operand Bm.
REQ-010 ALUop  input  4  operation code.
REQ-011 in_valid  input  1  request valid.
REQ-012 in_ready  output  1  block can accept a request.
REQ-013 out_valid  output  1  one-cycle pulse: ALUout and flags are new.
REQ-014 ALUout  output  WIDTH  registered result.
REQ-015 AltB  output  1  registered signed A<Bm.
REQ-016 flags  output  4  registered {N, Z, C, V}.
REQ-017 op_err  output  1  registered illegal-opcode indicator.

Function
REQ-018 A request SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-019 Opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed, zero-extended 0/1), 6 SLL, 7 SRL, 8 SRA, 9 MUL (low WIDTH bits of the unsigned product).
REQ-020 Shift ops SHALL use Bm[SHW-1:0] as the shift amount and ignore the upper bits.
REQ-021 For opcodes 10-15, the block SHALL set ALUout=0 and flags=0, and pulse op_err with out_valid, in the single-cycle path.
REQ-022 Opcodes 0-8 SHALL be single-cycle: when accepted at edge N, ALUout, AltB, flags and op_err SHALL update at edge N, and out_valid SHALL be high from edge N to edge N+1.
REQ-023 The FSM SHALL have states IDLE and MUL_BUSY; IDLE->MUL_BUSY on accepting MUL; MUL_BUSY->IDLE when the iteration counter reaches WIDTH-1.
REQ-024 MUL SHALL be shift-add, one multiplier bit per cycle, with operands latched at acceptance.
REQ-025 MUL accepted at edge N SHALL produce its result and out_valid at edge N+WIDTH.
REQ-026 in_ready SHALL be 1 in IDLE and 0 in MUL_BUSY, and in_valid SHALL be ignored while busy.
REQ-027 in_ready SHALL be combinational from the state only, with no dependence on in_valid.
REQ-028 AltB SHALL be captured at acceptance for every op, including MUL, using the signed comparison of A and Bm.
REQ-029 Z SHALL be set when ALUout==0, and N SHALL equal ALUout[WIDTH-1].
REQ-030 C SHALL be the carry-out for ADD and SUB (SUB carry = no borrow), the last bit shifted out for SLL, SRL and SRA (0 for a shift of 0), and 0 otherwise.
REQ-031 V SHALL be signed overflow for ADD and SUB, and 0 otherwise.
REQ-032 For MUL, C and V SHALL be 1 if any upper product bit is nonzero.
REQ-033 Outputs SHALL hold their last values when out_valid is 0.
REQ-034 out_valid SHALL never be high for two consecutive cycles from a single request.

Reset
REQ-035 When rst_n=0, the block SHALL asynchronously force state IDLE, counter 0, ALUout 0, AltB 0, flags 0, op_err 0 and out_valid 0; in_ready SHALL be 1 once in IDLE.
REQ-036 Reset asserted during MUL_BUSY SHALL abort the operation with no out_valid pulse.

Configuration
REQ-037 With macro ALU_PIPE_MUL_EN defined, opcode 9 SHALL be implemented per REQ-023 to REQ-025 and REQ-032.
REQ-038 Without ALU_PIPE_MUL_EN, opcode 9 SHALL be treated as illegal per REQ-021, MUL_BUSY SHALL be unreachable, and in_ready SHALL be constantly 1.

Verification
REQ-039 Reset, then an ADD request with A=16'h7FFF, Bm=16'h0001, ALUsrc=1 -> ALUout=16'h8000, flags N=1 Z=0 C=0 V=1, AltB=0, out_valid for 1 cycle.
REQ-040 A SUB request with A=5, Imm=5, ALUsrc=0 -> ALUout=0, Z=1, C=1, AltB=0; then a SLT request with A=16'hFFFF, B=1 -> ALUout=1, AltB=1.
REQ-041 A SRA request with A=16'h8001, Bm=16'h0011 (shift 1) -> ALUout=16'hC000, C=1.
REQ-042 With ALU_PIPE_MUL_EN defined, a MUL request with A=300, Bm=300 -> in_ready low for 16 cycles, and at edge N+16 ALUout=16'h5F90 and C=V=1; an in_valid asserted while busy is dropped.
REQ-043 Assert rst_n=0 8 cycles into a MUL -> state IDLE, no out_valid, outputs 0; the next ADD completes normally.
REQ-044 With ALUop=4'hC -> op_err=1, ALUout=0; repeat the REQ-042 stimulus without ALU_PIPE_MUL_EN -> op_err=1 after 1 cycle.
